// File: rtl/i2c_master.sv
// i2c_master: single-master I2C controller; START, address, register pointer, then N write bytes or a
// repeated-START read of N bytes, ending in STOP.
// Ports:
//   clk, reset (async, active-low)
//   i2c_wr_addr / i2c_rd_addr  command pulses; i2c_addr, i2c_byte_read latched with the pulse
//   i2c_in_valid/i2c_in_data/i2c_in_ready  one-byte write holding buffer
//   i2c_out_valid/i2c_out_data  received byte strobe
//   busy, ack_error (sticky until next command)
//   scl_oe, sda_oe  open-drain pull-low enables; sda_in synchronised SDA pad input
module i2c_master #(
    parameter int unsigned CLK_DIV = 125,
    parameter logic [7:0]  REG_PTR = 8'h00
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i2c_wr_addr,
    input  logic       i2c_rd_addr,
    input  logic [6:0] i2c_addr,
    input  logic [7:0] i2c_byte_read,
    input  logic       i2c_in_valid,
    input  logic [7:0] i2c_in_data,
    output logic       i2c_in_ready,
    output logic       i2c_out_valid,
    output logic [7:0] i2c_out_data,
    output logic       busy,
    output logic       ack_error,
    output logic       scl_oe,
    output logic       sda_oe,
    input  logic       sda_in
);
    typedef enum logic [3:0] {
        IDLE, START, SEND_ADDR, SEND_PTR, WR_DATA, RESTART, SEND_RADDR, RD_DATA, MST_ACK, STOP
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] div_q, div_d;
    logic [1:0]  qtr_q, qtr_d;
    logic [3:0]  bit_q, bit_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  buf_q, buf_d;
    logic        buf_full_q, buf_full_d;
    logic [6:0]  addr_q, addr_d;
    logic        rd_q, rd_d;
    logic        ack_error_q, ack_error_d;
    logic        out_valid_q, out_valid_d;
    logic [7:0]  out_data_q, out_data_d;
    logic        scl_q, scl_d;
    logic        sda_q, sda_d;
    logic        tx_state, tick, first, last;

    assign i2c_in_ready  = state_q == IDLE || (!rd_q && state_q != STOP && !buf_full_q);
    assign i2c_out_valid = out_valid_q;
    assign i2c_out_data  = out_data_q;
    assign busy          = state_q != IDLE;
    assign ack_error     = ack_error_q;
    assign scl_oe        = scl_q;
    assign sda_oe        = sda_q;

    always_comb begin
        tx_state    = state_q inside {SEND_ADDR, SEND_PTR, WR_DATA, SEND_RADDR};
        tick        = div_q == 16'(CLK_DIV - 1);
        // First cycle of a write byte: load from the buffer, or stall here (SCL low) while it is empty.
        first       = state_q == WR_DATA && bit_q == 4'd0 && qtr_q == 2'd0 && div_q == 16'd0;
        last        = tx_state ? bit_q == 4'd8 : state_q == RD_DATA ? bit_q == 4'd7 : 1'b1;
        state_d     = state_q;
        div_d       = (state_q == IDLE || tick || (first && !buf_full_q)) ? 16'd0 : div_q + 16'd1;
        qtr_d       = tick ? qtr_q + 2'd1 : qtr_q;
        bit_d       = bit_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        buf_d       = buf_q;
        buf_full_d  = buf_full_q;
        addr_d      = addr_q;
        rd_d        = rd_q;
        ack_error_d = ack_error_q;
        out_valid_d = 1'b0;
        out_data_d  = out_data_q;
        if (state_q == IDLE && (i2c_wr_addr || i2c_rd_addr)) begin
            state_d     = START;
            rd_d        = !i2c_wr_addr;
            addr_d      = i2c_addr;
            cnt_d       = i2c_byte_read;
            ack_error_d = 1'b0;
        end
        // Mid-SCL-high sample point: end of quarter 2.
        if (tick && qtr_q == 2'd2) begin
            if (tx_state && bit_q == 4'd8 && sda_in) ack_error_d = 1'b1;
            if (state_q == RD_DATA) begin
                shift_d = {shift_q[6:0], sda_in};
                if (bit_q == 4'd7) begin
                    out_valid_d = 1'b1;
                    out_data_d  = {shift_q[6:0], sda_in};
                end
            end
        end
        // End of a bit; ack_error_q doubles as the NACK flag of the ack bit just sampled.
        if (tick && qtr_q == 2'd3) begin
            bit_d = bit_q + 4'd1;
            if (!last) begin
                if (tx_state) shift_d = {shift_q[6:0], 1'b0};
            end else begin
                bit_d = 4'd0;
                unique case (state_q)
                    START: begin
                        state_d = SEND_ADDR;
                        shift_d = {addr_q, 1'b0};
                    end
                    SEND_ADDR: begin
                        state_d = ack_error_q ? STOP : SEND_PTR;
                        shift_d = REG_PTR;
                    end
                    SEND_PTR:   state_d = (ack_error_q || cnt_q == 8'd0) ? STOP : rd_q ? RESTART : WR_DATA;
                    WR_DATA: begin
                        state_d = (ack_error_q || cnt_q == 8'd1) ? STOP : WR_DATA;
                        cnt_d   = cnt_q - 8'd1;
                    end
                    RESTART: begin
                        state_d = SEND_RADDR;
                        shift_d = {addr_q, 1'b1};
                    end
                    SEND_RADDR: state_d = ack_error_q ? STOP : RD_DATA;
                    RD_DATA:    state_d = MST_ACK;
                    MST_ACK: begin
                        state_d = cnt_q == 8'd1 ? STOP : RD_DATA;
                        cnt_d   = cnt_q - 8'd1;
                    end
                    default:    state_d = IDLE;
                endcase
            end
        end
        if (first && buf_full_q) begin
            shift_d    = buf_q;
            buf_full_d = 1'b0;
        end
        if (i2c_in_valid && i2c_in_ready && state_q != IDLE) begin
            buf_d      = i2c_in_data;
            buf_full_d = 1'b1;
        end
        if (state_d == STOP) buf_full_d = 1'b0;
        // SCL high in quarters 2-3; SDA moves in quarter 1 (SCL low) and holds through quarter 0.
        scl_d = !(state_q inside {IDLE, START}) && !qtr_q[1];
        sda_d = state_q == IDLE     ? 1'b0 :
                qtr_q == 2'd0       ? sda_q :
                state_q == START    ? qtr_q[1] :
                state_q == RESTART  ? qtr_q == 2'd3 :
                state_q == STOP     ? qtr_q != 2'd3 :
                state_q == MST_ACK  ? cnt_q != 8'd1 :
                (tx_state && bit_q != 4'd8) ? !shift_q[7] : 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            div_q       <= '0;
            qtr_q       <= '0;
            bit_q       <= '0;
            cnt_q       <= '0;
            shift_q     <= '0;
            buf_q       <= '0;
            buf_full_q  <= 1'b0;
            addr_q      <= '0;
            rd_q        <= 1'b0;
            ack_error_q <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            scl_q       <= 1'b0;
            sda_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            qtr_q       <= qtr_d;
            bit_q       <= bit_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            buf_q       <= buf_d;
            buf_full_q  <= buf_full_d;
            addr_q      <= addr_d;
            rd_q        <= rd_d;
            ack_error_q <= ack_error_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            scl_q       <= scl_d;
            sda_q       <= sda_d;
        end
    end
endmodule

// File: tb/tb_i2c_master.sv
// tb_i2c_master: randomized and directed bench for i2c_master against a transaction-level bus model
// with an emulated slave at address 7'h68.
module tb_i2c_master;
    localparam int         CD   = 4;
    localparam logic [6:0] SLV  = 7'h68;
    localparam int         S_EV = 512;
    localparam int         P_EV = 513;

    logic       clk = 1'b0, reset = 1'b0;
    logic       wr = 1'b0, rd = 1'b0;
    logic [6:0] addr = '0;
    logic [7:0] nb = '0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = '0;
    logic       in_ready, out_valid, busy, ack_error, scl_oe, sda_oe, sda_in;
    logic [7:0] out_data;
    logic       s_drive = 1'b0;
    logic       scl, sda;

    assign scl    = !scl_oe;
    assign sda    = !sda_oe && !s_drive;
    assign sda_in = sda;

    always #5 clk = ~clk;

    i2c_master #(.CLK_DIV(CD)) dut (
        .clk(clk), .reset(reset), .i2c_wr_addr(wr), .i2c_rd_addr(rd), .i2c_addr(addr),
        .i2c_byte_read(nb), .i2c_in_valid(in_valid), .i2c_in_data(in_data), .i2c_in_ready(in_ready),
        .i2c_out_valid(out_valid), .i2c_out_data(out_data), .busy(busy), .ack_error(ack_error),
        .scl_oe(scl_oe), .sda_oe(sda_oe), .sda_in(sda_in)
    );

    int         n_cmp = 0, n_err = 0;
    int         mon_q[$];
    logic [7:0] out_q[$];
    int         exp_q[$];
    int         exp_o[$];
    logic [7:0] wd[8];
    logic [7:0] rbytes[8];

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int fr(input logic [7:0] b, input logic k);
        return int'({b, k});
    endfunction

    // Bus monitor and slave: logs START/STOP and every 9-bit frame {byte, ack level}.
    int         bitn, fidx, ridx;
    logic [8:0] sh;
    logic       rmode, hit, quiet, pscl, psda;
    always @(negedge clk) begin
        if (!reset) begin
            bitn = 0; fidx = 0; ridx = 0; rmode = 0; hit = 0; quiet = 0;
            s_drive = 0; pscl = 1; psda = 1; sh = '0;
        end else begin
            if (out_valid) out_q.push_back(out_data);
            if (pscl && scl && psda && !sda) begin
                mon_q.push_back(S_EV);
                bitn = 0; fidx = 0; ridx = 0; rmode = 0; quiet = 0;
            end else if (pscl && scl && !psda && sda) begin
                mon_q.push_back(P_EV);
                bitn = 0; fidx = 0; ridx = 0; rmode = 0; quiet = 0;
            end else if (!pscl && scl) begin
                sh = {sh[7:0], sda};
                bitn++;
                if (bitn == 9) begin
                    mon_q.push_back(int'(sh));
                    if (rmode && fidx > 0) begin
                        ridx++;
                        quiet = sh[0];
                    end
                    fidx++;
                    bitn = 0;
                end
            end else if (pscl && !scl) begin
                if (bitn == 8) begin
                    if (fidx == 0) begin
                        hit   = sh[7:1] == SLV;
                        rmode = sh[0];
                    end
                    s_drive = hit && !(rmode && fidx > 0);
                end else begin
                    s_drive = rmode && fidx > 0 && !quiet && ridx < 8 && !rbytes[ridx][7-bitn];
                end
            end
            pscl = scl;
            psda = sda;
        end
    end

    // Reference: expected bus frames and received bytes for one transaction.
    task automatic build(input bit is_rd, input logic [6:0] a, input int n);
        bit ok;
        ok = a == SLV;
        exp_q = {};
        exp_o = {};
        exp_q.push_back(S_EV);
        exp_q.push_back(fr({a, 1'b0}, !ok));
        if (ok) begin
            exp_q.push_back(fr(8'h00, 1'b0));
            if (n > 0 && !is_rd) begin
                for (int i = 0; i < n; i++) exp_q.push_back(fr(wd[i], 1'b0));
            end else if (n > 0) begin
                exp_q.push_back(S_EV);
                exp_q.push_back(fr({a, 1'b1}, 1'b0));
                for (int i = 0; i < n; i++) begin
                    exp_q.push_back(fr(rbytes[i], i == n - 1));
                    exp_o.push_back(int'(rbytes[i]));
                end
            end
        end
        exp_q.push_back(P_EV);
    endtask

    task automatic xact(input bit do_wr, input bit do_rd, input logic [6:0] a, input int n,
                        input int gate1, input bit extra_rd);
        int qb, ob, di, cyc;
        bit is_rd;
        is_rd = !do_wr;
        build(is_rd, a, n);
        qb = mon_q.size();
        ob = out_q.size();
        di = 0;
        @(posedge clk); #1;
        wr = do_wr; rd = do_rd; addr = a; nb = 8'(n);
        @(posedge clk); #1;
        wr = 0; rd = 0; addr = 7'h7f; nb = 8'hff;
        chk("busy_rise", busy, 1);
        chk("ackerr_clr", ack_error, 0);
        cyc = 0;
        while (busy && cyc < 20000) begin
            in_valid = 0;
            if (!is_rd && di < n && in_ready && (di != 1 || cyc >= gate1)) begin
                in_valid = 1;
                in_data  = wd[di];
                di++;
            end
            rd = extra_rd && cyc == 50;
            if (gate1 > 0 && cyc == 600) begin
                chk("hold_scl", scl_oe, 1);
                chk("hold_rdy", in_ready, 1);
            end
            if (is_rd && cyc == 30) chk("rd_rdy", in_ready, 0);
            @(posedge clk); #1;
            cyc++;
        end
        in_valid = 0;
        rd = 0;
        chk("timeout", cyc < 20000, 1);
        chk("ready_end", in_ready, 1);
        chk("ack_error", ack_error, a != SLV);
        @(negedge clk); #1;
        chk("ev_count", mon_q.size() - qb, exp_q.size());
        for (int i = 0; i < exp_q.size() && qb + i < mon_q.size(); i++) chk("event", mon_q[qb+i], exp_q[i]);
        chk("rx_count", out_q.size() - ob, exp_o.size());
        for (int i = 0; i < exp_o.size() && ob + i < out_q.size(); i++) chk("rx_data", out_q[ob+i], exp_o[i]);
    endtask

    initial begin
        int n, rdm;
        logic [6:0] a;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_scl", scl_oe, 0);
        chk("rst_sda", sda_oe, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ackerr", ack_error, 0);
        chk("rst_oval", out_valid, 0);
        chk("rst_odata", out_data, 0);
        chk("rst_ready", in_ready, 1);
        reset = 1;
        @(posedge clk); #1;
        wd[0] = 8'h30; wd[1] = 8'h15; wd[2] = 8'h12;
        xact(1, 0, SLV, 3, 0, 0);
        rbytes[0] = 8'h45; rbytes[1] = 8'h59; rbytes[2] = 8'h23;
        xact(0, 1, SLV, 3, 0, 0);
        xact(1, 0, 7'h50, 2, 0, 0);
        wd[0] = 8'hA5; wd[1] = 8'h3C;
        xact(1, 0, SLV, 2, 620, 0);
        wd[0] = 8'h81; wd[1] = 8'h7E;
        xact(1, 1, SLV, 2, 0, 1);
        xact(0, 1, SLV, 0, 0, 0);
        // Reset in the middle of the address byte.
        @(posedge clk); #1;
        wr = 1; addr = SLV; nb = 8'd2;
        @(posedge clk); #1;
        wr = 0;
        repeat (100) @(posedge clk);
        #1;
        chk("pre_rst_scl", scl_oe, 1);
        reset = 0;
        #1;
        chk("mid_rst_scl", scl_oe, 0);
        chk("mid_rst_sda", sda_oe, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_ready", in_ready, 1);
        chk("mid_rst_odata", out_data, 0);
        @(posedge clk); #1;
        reset = 1;
        @(posedge clk); #1;
        for (int t = 0; t < 12; t++) begin
            for (int i = 0; i < 8; i++) begin
                wd[i]     = 8'($urandom);
                rbytes[i] = 8'($urandom);
            end
            a   = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127)) : SLV;
            n   = $urandom_range(0, 4);
            rdm = $urandom_range(0, 1);
            xact(rdm == 0, rdm == 1, a, n, 0, 0);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/i2c_master.md
I2C_MASTER -- requirements
Module: i2c_master

Interface
REQ-001 SHALL have parameter CLK_DIV, default 125, giving clk cycles per SCL quarter-period (SCL = f_clk/(4*CLK_DIV)); legal 2..65535.
REQ-002 SHALL have parameter REG_PTR, default 8'h00, the register pointer byte sent after every address.
REQ-003 Ports, in this order:
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- i2c_wr_addr  in  1  one-cycle pulse; start a write transaction.
- i2c_rd_addr  in  1  one-cycle pulse; start a read transaction.
- i2c_addr  in  7  slave address, sampled with the command pulse.
- i2c_byte_read  in  8  data-byte count N, sampled with the command pulse.
- i2c_in_valid  in  1  one-cycle pulse; i2c_in_data is a write byte.
- i2c_in_data  in  8  write data byte.
- i2c_in_ready  out  1  high = holding buffer empty and idle or writing.
- i2c_out_valid  out  1  one-cycle pulse per received byte.
- i2c_out_data  out  8  received byte, valid with i2c_out_valid.
- busy  out  1  high from command accept until STOP completes.
- ack_error  out  1  sticky; set on any slave NACK, cleared on next accepted command.
- scl_oe, sda_oe  out  1 each  open-drain pull-low enables; 1 = drive line low.
- sda_in  in  1  SDA pad input, already synchronised externally.

Function
REQ-004 Commands SHALL be accepted only while busy=0; if wr and rd pulse together, write SHALL win; pulses while busy SHALL be ignored.
REQ-005 busy SHALL rise the cycle after command accept; i2c_addr and i2c_byte_read SHALL be latched at accept.
REQ-006 States: IDLE, START, SEND_ADDR, SEND_PTR, WR_DATA, RESTART, SEND_RADDR, RD_DATA, MST_ACK, STOP; each bit occupies 4 quarter-periods, SCL high in quarters 2-3.
REQ-007 Write: START, {addr,0}, slave ACK, REG_PTR, ACK, then N bytes from holding buffer, each with ACK check, then STOP.
REQ-008 Read: START, {addr,0}, ACK, REG_PTR, ACK, RESTART, {addr,1}, ACK, N bytes received MSB first; master ACKs bytes 1..N-1, NACKs byte N, then STOP.
REQ-009 Holding buffer SHALL be one byte; i2c_in_valid SHALL be captured whenever the buffer is empty, including the cycle right after wr_addr; i2c_in_ready SHALL fall the cycle after capture.
REQ-010 Buffer SHALL empty (i2c_in_ready rises next cycle) when its byte loads into the shifter at start of that byte's WR_DATA.
REQ-011 If WR_DATA needs a byte and the buffer is empty, master SHALL hold SCL low (scl_oe=1) indefinitely until a byte arrives.
REQ-012 i2c_in_valid while buffer full, in IDLE, or during a read SHALL be ignored; i2c_in_ready SHALL be 0 throughout a read.
REQ-013 i2c_out_valid SHALL pulse one cycle after the 8th bit of each read byte is sampled (sampled mid-SCL-high).
REQ-014 N=0: transaction SHALL end with STOP after REG_PTR ACK; no data phase, no out_valid.
REQ-015 Any NACK in SEND_ADDR/SEND_PTR/SEND_RADDR/WR_DATA SHALL set ack_error, flush the buffer, go to STOP, then IDLE.
REQ-016 START: SDA falls with SCL high; STOP: SDA rises with SCL high; RESTART: SDA released, SCL high, then SDA low.
REQ-017 SDA SHALL change only while SCL is low, except START/RESTART/STOP.
REQ-018 busy SHALL fall the cycle after STOP's final quarter; i2c_in_ready SHALL then be 1.

Reset
REQ-019 While reset=0: state IDLE, buffer empty, scl_oe=0, sda_oe=0, busy=0, ack_error=0, i2c_out_valid=0, i2c_out_data=8'h00, i2c_in_ready=1, divider 0.
REQ-020 Reset mid-transaction SHALL release both lines immediately; no STOP generated.

Verification
REQ-021 Write addr 7'h68, N=3, bytes 8'h30,8'h15,8'h12 (first byte one cycle after wr pulse), ACKing slave -> SDA D0,00,30,15,12, STOP, busy low, ack_error=0.
REQ-022 Read addr 7'h68, N=3, slave returns 8'h45,8'h59,8'h23 -> D0,00, RESTART, D1, three out_valid pulses with those values, ACK,ACK,NACK, STOP.
REQ-023 Write to 7'h50 with no slave (SDA high at ACK) -> ack_error=1 after address byte, STOP, idle; next command clears ack_error.
REQ-024 Write N=2 with second byte delayed 10 SCL periods -> SCL held low after first data ACK until byte arrives, then continues correctly.
REQ-025 wr and rd pulsed same cycle, then rd pulsed while busy -> only write performed; reset=0 mid-byte -> scl_oe=sda_oe=0 same cycle, busy=0.
REQ-026 Read N=0 -> D0,00, STOP; no out_valid.
